// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl_pkg
// Brief    : Shared types and default io addresses for the CPU run controller.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_run_ctrl_pkg;

    // Controller state encoding; the numeric values are visible on the state port
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_RUN    = 2'd2,
        ST_IOWAIT = 2'd3
    } state_t;

    // Default io addresses of the input status and input data registers
    localparam logic [7:0] c_in_stat_addr = 8'h08;
    localparam logic [7:0] c_in_data_addr = 8'h0C;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_run_div.sv
`default_nettype none
// ============================================================================
// Module   : run_div
// Brief    : Free-run issue-slot divider. Counts 0..RUN_DIV-1 while not
//            cleared; o_slot is high while the count sits at RUN_DIV-1.
// Revision : 1.0 - initial release
// ============================================================================
module run_div #(
    parameter int RUN_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_slot
);

    localparam int               c_cnt_w = $clog2(RUN_DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(RUN_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign o_slot = (r_cnt == c_last);

    // Divider count: held at zero while cleared, wraps after the slot
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (o_slot) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : Single-step / free-run controller for a teaching CPU. Issues
//            one-cycle clock enables, stalls on reads of an empty input
//            register and optionally stops free-run at a breakpoint PC.
//            Build option: define CPU_RUN_CTRL_BRK_EN to include the
//            breakpoint register, compare and brk_hit flag.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int         RUN_DIV      = 4,
    parameter logic [7:0] IN_STAT_ADDR = c_in_stat_addr,
    parameter logic [7:0] IN_DATA_ADDR = c_in_data_addr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        cont,
    input  logic        ent,
    input  logic [31:0] in_val,
    input  logic        brk_set,
    input  logic        brk_clr,
    input  logic [31:0] brk_val,
    input  logic [31:0] pc,
    input  logic        io_rd,
    input  logic [7:0]  io_addr,
    output logic        cpu_ce,
    output logic [31:0] io_din,
    output logic        in_vld,
    output logic        pause,
    output logic [1:0]  state,
    output logic        brk_hit,
    output logic [31:0] instr_cnt
);

    state_t      r_state, w_state_nxt;
    state_t      r_ret, w_ret_nxt;
    logic        r_resume, w_resume_nxt;
    logic        r_cpu_ce, w_issue;
    logic        w_brk_stop;
    logic        w_brk_match;
    logic        w_blocked;
    logic        w_slot;
    logic        w_div_clr;
    logic        w_consume;
    logic [31:0] r_in_data;
    logic        r_in_vld;
    logic [31:0] r_instr_cnt;

    assign w_blocked = io_rd && (io_addr == IN_DATA_ADDR) && !r_in_vld;
    assign w_consume = r_cpu_ce && io_rd && (io_addr == IN_DATA_ADDR);
    // Divider restarts from zero on every entry into RUN
    assign w_div_clr = (r_state != ST_RUN);

    run_div #(
        .RUN_DIV (RUN_DIV)
    ) u_run_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_div_clr),
        .o_slot (w_slot)
    );

`ifdef CPU_RUN_CTRL_BRK_EN
    logic        r_brk_arm;
    logic [31:0] r_brk_addr;
    logic        r_brk_hit;

    assign w_brk_match = r_brk_arm && (pc == r_brk_addr);
    assign brk_hit     = r_brk_hit;

    // Breakpoint register: disarm wins over a simultaneous load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brk_arm  <= 1'b0;
            r_brk_addr <= 32'h0;
        end else if (brk_clr) begin
            r_brk_arm  <= 1'b0;
        end else if (brk_set) begin
            r_brk_arm  <= 1'b1;
            r_brk_addr <= brk_val;
        end
    end

    // Sticky breakpoint-hit flag, acknowledged by the next step or cont
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brk_hit <= 1'b0;
        end else if (step || cont) begin
            r_brk_hit <= 1'b0;
        end else if (w_brk_stop) begin
            r_brk_hit <= 1'b1;
        end
    end
`else
    logic w_brk_unused;

    assign w_brk_match  = 1'b0;
    assign brk_hit      = 1'b0;
    assign w_brk_unused = ^{brk_set, brk_clr, brk_val, pc, w_brk_stop};
`endif

    // Next-state and issue decision; a slot issue shows up as cpu_ce next cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_ret_nxt    = r_ret;
        w_resume_nxt = r_resume;
        w_issue      = 1'b0;
        w_brk_stop   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cont) begin
                    w_state_nxt  = ST_RUN;
                    w_resume_nxt = 1'b1;
                end else if (step) begin
                    w_state_nxt  = ST_STEP;
                end
            end
            ST_STEP: begin
                if (w_blocked) begin
                    w_state_nxt = ST_IOWAIT;
                    w_ret_nxt   = ST_STEP;
                end else begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cont) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_slot) begin
                    w_resume_nxt = 1'b0;
                    if (w_brk_match && !r_resume) begin
                        w_state_nxt = ST_IDLE;
                        w_brk_stop  = 1'b1;
                    end else if (w_blocked) begin
                        w_state_nxt = ST_IOWAIT;
                        w_ret_nxt   = ST_RUN;
                    end else begin
                        w_issue     = 1'b1;
                    end
                end
            end
            ST_IOWAIT: begin
                // Abort takes precedence over data arrival
                if (cont) begin
                    w_state_nxt = ST_IDLE;
                end else if (ent) begin
                    w_state_nxt = r_ret;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller state, return state, resume flag and registered clock enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ret    <= ST_STEP;
            r_resume <= 1'b0;
            r_cpu_ce <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ret    <= w_ret_nxt;
            r_resume <= w_resume_nxt;
            r_cpu_ce <= w_issue;
        end
    end

    // Input register: new data beats a same-cycle consume
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_data <= 32'h0;
            r_in_vld  <= 1'b0;
        end else if (ent) begin
            r_in_data <= in_val;
            r_in_vld  <= 1'b1;
        end else if (w_consume) begin
            r_in_vld  <= 1'b0;
        end
    end

    // Executed-instruction counter, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_cnt <= 32'h0;
        end else if (r_cpu_ce) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    // io read mux; unmapped addresses read as zero
    always_comb begin
        io_din = 32'h0;
        if (io_addr == IN_STAT_ADDR) begin
            io_din = {31'b0, r_in_vld};
        end else if (io_addr == IN_DATA_ADDR) begin
            io_din = r_in_data;
        end
    end

    assign cpu_ce    = r_cpu_ce;
    assign in_vld    = r_in_vld;
    assign pause     = (r_state != ST_RUN);
    assign state     = r_state;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire
